// File: rtl/pipe_pkg.sv
// Shared pipeline types for the 16-bit processor: control bundles, ALU op
// classes and the ID/EX slot record.
package pipe_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 3;

  localparam logic [REG_W-1:0] REG_ZERO = 3'd0;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_RSVD  = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic    alu_src;
    alu_op_e alu_op;
    logic    reg_dest;
  } ex_ctrl_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic branch;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  // Everything EX needs from one instruction; an all-zero record is a bubble.
  typedef struct packed {
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic [DATA_W-1:0] addr;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    ex_ctrl_t          ex;
    mem_ctrl_t         mem;
    wb_ctrl_t          wb;
    logic              valid;
  } id_ex_t;

  // What the ID/EX register does on the coming edge, in priority order.
  typedef enum logic [1:0] {
    ACT_HOLD   = 2'b00,
    ACT_FLUSH  = 2'b01,
    ACT_BUBBLE = 2'b10,
    ACT_LOAD   = 2'b11
  } slot_action_e;

  function automatic logic regMatch(input logic en,
                                    input logic [REG_W-1:0] a,
                                    input logic [REG_W-1:0] b);
    return en && (a == b);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard equation: the ID instruction reads the register that the
// load currently in EX has not yet fetched from memory.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic             validEx,
  input  logic             memReadEx,
  input  logic [REG_W-1:0] loadDest,
  input  logic             useRs,
  input  logic [REG_W-1:0] rs,
  input  logic             useRt,
  input  logic [REG_W-1:0] rt,
  output logic             hazard
);

  // Register 0 is hard-wired, so a load targeting it can never be consumed.
  assign hazard = validEx && memReadEx && (loadDest != REG_ZERO) &&
                  (regMatch(useRs, rs, loadDest) || regMatch(useRt, rt, loadDest));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble injection, branch flush,
// global hold and saturating bubble/flush event counters.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [15:0]       pc4_id,
  input  logic [15:0]       rd1_id,
  input  logic [15:0]       rd2_id,
  input  logic [15:0]       imm_id,
  input  logic [2:0]        rs_id,
  input  logic [2:0]        rt_id,
  input  logic [2:0]        rd_id,
  input  logic              use_rs_id,
  input  logic              use_rt_id,
  input  logic              alu_src_id,
  input  logic              reg_dest_id,
  input  logic [1:0]        alu_op_id,
  input  logic              mem_read_id,
  input  logic              mem_write_id,
  input  logic              branch_id,
  input  logic              reg_write_id,
  input  logic              mem_to_reg_id,
  input  logic              flush,
  input  logic              hold,
  output logic [15:0]       PC4,
  output logic [15:0]       data1ALU,
  output logic [15:0]       data2ALU,
  output logic [15:0]       address,
  output logic [2:0]        reg1,
  output logic [2:0]        reg2,
  output logic [2:0]        reg3,
  output logic              ALUSrc_EX,
  output logic              regDestEx,
  output logic [1:0]        ALUOpEx,
  output logic              mem_read_ex,
  output logic              mem_write_ex,
  output logic              branch_ex,
  output logic              reg_write_ex,
  output logic              mem_to_reg_ex,
  output logic              valid_ex,
  output logic              stall,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  id_ex_t       exSlot;
  id_ex_t       idSlot;
  slot_action_e action;
  logic         hazard;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    idSlot             = '0;
    idSlot.pc4         = pc4_id;
    idSlot.data1       = rd1_id;
    idSlot.data2       = rd2_id;
    idSlot.addr        = imm_id;
    idSlot.rs          = rs_id;
    idSlot.rt          = rt_id;
    idSlot.rd          = rd_id;
    idSlot.ex.alu_src  = alu_src_id;
    idSlot.ex.alu_op   = alu_op_e'(alu_op_id);
    idSlot.ex.reg_dest = reg_dest_id;
    idSlot.mem.mem_read  = mem_read_id;
    idSlot.mem.mem_write = mem_write_id;
    idSlot.mem.branch    = branch_id;
    idSlot.wb.reg_write  = reg_write_id;
    idSlot.wb.mem_to_reg = mem_to_reg_id;
    idSlot.valid       = 1'b1;
  end

  hazard_detect u_hazard (
    .validEx   (exSlot.valid),
    .memReadEx (exSlot.mem.mem_read),
    .loadDest  (exSlot.rt),
    .useRs     (use_rs_id),
    .rs        (rs_id),
    .useRt     (use_rt_id),
    .rt        (rt_id),
    .hazard    (hazard)
  );

  // hold outranks flush, which outranks the load-use bubble.
  always_comb begin
    action = ACT_LOAD;
    if (hold)        action = ACT_HOLD;
    else if (flush)  action = ACT_FLUSH;
    else if (hazard) action = ACT_BUBBLE;
  end

  assign stall = (action == ACT_BUBBLE);

  // NOTE: sequential state uses non-blocking assignments only; the slot is a
  // handful of flops, not a memory, so it is cleared by the async reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exSlot     <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      unique case (action)
        ACT_HOLD: ;
        ACT_FLUSH: begin
          exSlot <= '0;
          if (flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_ONE;
        end
        ACT_BUBBLE: begin
          exSlot <= '0;
          if (bubble_cnt != CNT_MAX) bubble_cnt <= bubble_cnt + CNT_ONE;
        end
        ACT_LOAD: exSlot <= idSlot;
        default: exSlot <= '0;
      endcase
    end
  end

  assign PC4           = exSlot.pc4;
  assign data1ALU      = exSlot.data1;
  assign data2ALU      = exSlot.data2;
  assign address       = exSlot.addr;
  assign reg1          = exSlot.rs;
  assign reg2          = exSlot.rt;
  assign reg3          = exSlot.rd;
  assign ALUSrc_EX     = exSlot.ex.alu_src;
  assign regDestEx     = exSlot.ex.reg_dest;
  assign ALUOpEx       = exSlot.ex.alu_op;
  assign mem_read_ex   = exSlot.mem.mem_read;
  assign mem_write_ex  = exSlot.mem.mem_write;
  assign branch_ex     = exSlot.mem.branch;
  assign reg_write_ex  = exSlot.wb.reg_write;
  assign mem_to_reg_ex = exSlot.wb.mem_to_reg;
  assign valid_ex      = exSlot.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a behavioural
// instruction-slot model; counters built 2 bits wide to reach saturation.
module tb_id_ex_stage;

  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic [15:0] pc4, rd1, rd2, imm;
    logic [2:0]  rs, rt, rd;
    logic        useRs, useRt;
    logic        aluSrc, regDest;
    logic [1:0]  aluOp;
    logic        memRead, memWrite, branch, regWrite, memToReg;
  } idIn_t;

  logic clock = 1'b0;
  logic reset_n;
  logic [15:0] pc4_id, rd1_id, rd2_id, imm_id;
  logic [2:0]  rs_id, rt_id, rd_id;
  logic use_rs_id, use_rt_id, alu_src_id, reg_dest_id;
  logic [1:0] alu_op_id;
  logic mem_read_id, mem_write_id, branch_id, reg_write_id, mem_to_reg_id;
  logic flush, hold;
  logic [15:0] PC4, data1ALU, data2ALU, address;
  logic [2:0]  reg1, reg2, reg3;
  logic ALUSrc_EX, regDestEx;
  logic [1:0] ALUOpEx;
  logic mem_read_ex, mem_write_ex, branch_ex, reg_write_ex, mem_to_reg_ex;
  logic valid_ex, stall;
  logic [CW-1:0] bubble_cnt, flush_cnt;

  id_ex_stage #(.CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n),
    .pc4_id(pc4_id), .rd1_id(rd1_id), .rd2_id(rd2_id), .imm_id(imm_id),
    .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
    .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
    .alu_src_id(alu_src_id), .reg_dest_id(reg_dest_id), .alu_op_id(alu_op_id),
    .mem_read_id(mem_read_id), .mem_write_id(mem_write_id), .branch_id(branch_id),
    .reg_write_id(reg_write_id), .mem_to_reg_id(mem_to_reg_id),
    .flush(flush), .hold(hold),
    .PC4(PC4), .data1ALU(data1ALU), .data2ALU(data2ALU), .address(address),
    .reg1(reg1), .reg2(reg2), .reg3(reg3),
    .ALUSrc_EX(ALUSrc_EX), .regDestEx(regDestEx), .ALUOpEx(ALUOpEx),
    .mem_read_ex(mem_read_ex), .mem_write_ex(mem_write_ex), .branch_ex(branch_ex),
    .reg_write_ex(reg_write_ex), .mem_to_reg_ex(mem_to_reg_ex),
    .valid_ex(valid_ex), .stall(stall),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model: which instruction occupies EX (if any) plus event tallies.
  idIn_t mRec;
  logic  mValid;
  int    mBub, mFl;
  idIn_t cur;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mRec = '0; mValid = 1'b0; mBub = 0; mFl = 0;
  endtask

  function automatic logic modelHazard(input idIn_t x);
    return mValid && mRec.memRead && (mRec.rt != 3'd0) &&
           ((x.useRs && x.rs == mRec.rt) || (x.useRt && x.rt == mRec.rt));
  endfunction

  function automatic logic [127:0] expVec();
    if (!mValid) return '0;
    return {mRec.pc4, mRec.rd1, mRec.rd2, mRec.imm, mRec.rs, mRec.rt, mRec.rd,
            mRec.aluSrc, mRec.regDest, mRec.aluOp, mRec.memRead, mRec.memWrite,
            mRec.branch, mRec.regWrite, mRec.memToReg, 1'b1};
  endfunction

  function automatic logic [127:0] obsVec();
    return {PC4, data1ALU, data2ALU, address, reg1, reg2, reg3, ALUSrc_EX, regDestEx,
            ALUOpEx, mem_read_ex, mem_write_ex, branch_ex, reg_write_ex,
            mem_to_reg_ex, valid_ex};
  endfunction

  task automatic drive(input idIn_t x);
    cur = x;
    pc4_id = x.pc4; rd1_id = x.rd1; rd2_id = x.rd2; imm_id = x.imm;
    rs_id = x.rs; rt_id = x.rt; rd_id = x.rd;
    use_rs_id = x.useRs; use_rt_id = x.useRt;
    alu_src_id = x.aluSrc; reg_dest_id = x.regDest; alu_op_id = x.aluOp;
    mem_read_id = x.memRead; mem_write_id = x.memWrite; branch_id = x.branch;
    reg_write_id = x.regWrite; mem_to_reg_id = x.memToReg;
  endtask

  // Called just after a rising edge with inputs already driven.
  task automatic step();
    logic haz;
    #1;
    haz = modelHazard(cur);
    check("stall", 128'(stall), 128'(haz && !flush && !hold));
    @(posedge clock);
    if (hold) begin
    end else if (flush) begin
      mValid = 1'b0; mRec = '0;
      if (mFl < CMAX) mFl++;
    end else if (haz) begin
      mValid = 1'b0; mRec = '0;
      if (mBub < CMAX) mBub++;
    end else begin
      mValid = 1'b1; mRec = cur;
    end
    #1;
    check("ex_slot", obsVec(), expVec());
    check("bubble_cnt", 128'(bubble_cnt), 128'(mBub));
    check("flush_cnt", 128'(flush_cnt), 128'(mFl));
  endtask

  function automatic idIn_t randId();
    idIn_t x;
    x.pc4 = 16'($urandom); x.rd1 = 16'($urandom); x.rd2 = 16'($urandom);
    x.imm = 16'($urandom);
    x.rs = 3'($urandom_range(0, 3)); x.rt = 3'($urandom_range(0, 3));
    x.rd = 3'($urandom_range(0, 7));
    x.useRs = 1'($urandom); x.useRt = 1'($urandom);
    x.aluSrc = 1'($urandom); x.regDest = 1'($urandom); x.aluOp = 2'($urandom);
    x.memRead = ($urandom_range(0, 2) == 0); x.memWrite = 1'($urandom);
    x.branch = 1'($urandom); x.regWrite = 1'($urandom); x.memToReg = 1'($urandom);
    return x;
  endfunction

  function automatic idIn_t loadOp(input logic [2:0] dst);
    idIn_t x = '0;
    x.pc4 = 16'h0010; x.rd1 = 16'h0100; x.imm = 16'h0004; x.rs = 3'd1; x.rt = dst;
    x.useRs = 1'b1; x.aluSrc = 1'b1; x.memRead = 1'b1; x.regWrite = 1'b1;
    x.memToReg = 1'b1;
    return x;
  endfunction

  function automatic idIn_t readOp(input logic [2:0] src);
    idIn_t x = '0;
    x.pc4 = 16'h0014; x.rd1 = 16'h1234; x.rd2 = 16'h4321; x.rs = src; x.rt = 3'd5;
    x.rd = 3'd6; x.useRs = 1'b1; x.useRt = 1'b1; x.regDest = 1'b1; x.aluOp = 2'b10;
    x.regWrite = 1'b1;
    return x;
  endfunction

  initial begin
    idIn_t x;
    reset_n = 1'b0; flush = 1'b0; hold = 1'b0;
    drive(randId());
    modelReset();
    #2;
    check("reset_slot", obsVec(), 128'd0);
    check("reset_stall", 128'(stall), 128'd0);
    check("reset_bubble", 128'(bubble_cnt), 128'd0);
    #6 reset_n = 1'b1;

    // Straight-line add.
    x = '0; x.rd1 = 16'h0005; x.imm = 16'hFFFE; x.rs = 3'd1; x.rt = 3'd2; x.rd = 3'd3;
    x.useRs = 1'b1; x.useRt = 1'b1; x.regWrite = 1'b1;
    drive(x); step();
    check("add_data1", 128'(data1ALU), 128'h0005);
    check("add_addr", 128'(address), 128'hFFFE);
    check("add_reg3", 128'(reg3), 128'd3);
    check("add_valid", 128'(valid_ex), 128'd1);

    // Load-use: one bubble, then the held add enters EX.
    drive(loadOp(3'd2)); step();
    drive(readOp(3'd2)); step();
    check("bubble_valid", 128'(valid_ex), 128'd0);
    check("bubble_ctrl", 128'({mem_write_ex, reg_write_ex, branch_ex, mem_read_ex}), 128'd0);
    check("bubble_cnt1", 128'(bubble_cnt), 128'd1);
    step();
    check("held_enters", 128'({valid_ex, reg3}), 128'({1'b1, 3'd6}));

    // Load into register 0 never stalls.
    drive(loadOp(3'd0)); step();
    drive(readOp(3'd0)); step();
    check("r0_valid", 128'(valid_ex), 128'd1);
    check("r0_bubble", 128'(bubble_cnt), 128'd1);

    // Flush coincident with a load-use hazard.
    drive(loadOp(3'd2)); step();
    drive(readOp(3'd2)); flush = 1'b1; step(); flush = 1'b0;
    check("flush_cnt1", 128'(flush_cnt), 128'd1);
    check("flush_no_bub", 128'(bubble_cnt), 128'd1);

    // Hold for three cycles over a pending hazard, then one bubble.
    drive(loadOp(3'd3)); step();
    x = readOp(3'd1); x.rt = 3'd3; drive(x);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("hold_frozen", 128'({valid_ex, mem_read_ex, reg2}), 128'({2'b11, 3'd3}));
    hold = 1'b0; step();
    check("post_hold_bub", 128'(bubble_cnt), 128'd2);
    step();

    // Drive the bubble counter into saturation.
    for (int i = 0; i < 3; i++) begin
      drive(loadOp(3'd4)); step();
      drive(readOp(3'd4)); step(); step();
    end
    check("bubble_sat", 128'(bubble_cnt), 128'(CMAX));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      flush = ($urandom_range(0, 9) == 0);
      hold  = ($urandom_range(0, 6) == 0);
      if (!stall || $urandom_range(0, 1) == 0) drive(randId());
      step();
    end
    flush = 1'b0; hold = 1'b0;

    // Asynchronous reset mid-stall.
    drive(loadOp(3'd2)); step();
    drive(readOp(3'd2));
    #2 reset_n = 1'b0;
    #1;
    modelReset();
    check("async_slot", obsVec(), 128'd0);
    check("async_cnts", 128'({bubble_cnt, flush_cnt}), 128'd0);
    check("async_stall", 128'(stall), 128'd0);
    #1 reset_n = 1'b1;
    step();
    check("post_reset_load", 128'({valid_ex, reg1}), 128'({1'b1, 3'd2}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register and load-use hazard unit between ID and EX in the 16-bit processor. It captures decoded operands, the sign-extended immediate, register specifiers and control bits from ID, and presents them to EX. It detects a load-use hazard against the instruction in EX, stalls PC and IF/ID, and injects a bubble. It also honours a branch flush and a global hold, and keeps saturating bubble and flush counters.

## Interface
- CNT_W, 16, width of the bubble and flush counters
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- pc4_id  in  16  PC+4 of the ID instruction
- rd1_id, rd2_id  in  16 each  register-file read data
- imm_id  in  16  sign-extended immediate; [2:0] carries funct
- rs_id, rt_id, rd_id  in  3 each  register specifiers
- use_rs_id, use_rt_id  in  1 each  ID instruction reads rs / rt
- alu_src_id, reg_dest_id  in  1 each  control bits
- alu_op_id  in  2  ALU operation class
- mem_read_id, mem_write_id, branch_id, reg_write_id, mem_to_reg_id  in  1 each  MEM/WB control bits
- flush  in  1  branch taken, resolved downstream
- hold  in  1  downstream freeze (memory wait)
- PC4, data1ALU, data2ALU, address  out  16 each  registered copies for EX
- reg1, reg2, reg3  out  3 each  registered rs, rt, rd
- ALUSrc_EX, regDestEx  out  1 each; ALUOpEx  out  2
- mem_read_ex, mem_write_ex, branch_ex, reg_write_ex, mem_to_reg_ex  out  1 each
- valid_ex  out  1  EX slot holds a real instruction
- stall  out  1  combinational; freezes PC and IF/ID
- bubble_cnt, flush_cnt  out  CNT_W each  saturating event counters

## Operation
- Hazard: hazard = valid_ex & mem_read_ex & (reg2 != 0) & ((use_rs_id & rs_id == reg2) | (use_rt_id & rt_id == reg2)). Register 0 never triggers a hazard.
- stall = hazard & ~flush & ~hold.
- The register updates at each clock edge using the first matching rule:
  1. hold=1: every register keeps its value. Counters do not change.
  2. flush=1: the slot is cleared. All outputs go to 0 and valid_ex goes to 0. flush_cnt increments.
  3. hazard=1: a bubble is injected. The slot is cleared the same way as a flush. bubble_cnt increments.
  4. Otherwise the ID values are loaded and valid_ex goes to 1.
- A cleared slot has all control bits at 0, so it cannot write memory or registers and cannot branch.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Reset: all outputs, valid_ex and both counters go to 0 immediately, with no clock needed.
- Reset takes effect mid-stall or mid-hold. After reset is released, the first edge loads ID normally.

## Timing
- Latency: 1 cycle from ID to EX.
- stall is combinational from the current EX slot and the ID inputs. It is valid in the same cycle.
- A load followed immediately by a dependent instruction gives exactly one bubble. On the next cycle mem_read_ex is 0 and the held ID instruction enters EX.
- A dependency two or more instructions after the load gives no stall. Forwarding handles it.
- flush and hazard in the same cycle: flush wins. stall=0, and only flush_cnt increments.
- hold and either event in the same cycle: hold wins. stall=0 and nothing is counted. The hazard is re-evaluated once hold drops.

## Structure
- Shared package pipe_pkg:
  - ALUOp encodings: 00 add, 01 sub, 10 R-type funct, 11 reserved
  - ex_ctrl_t bundle: alu_src, alu_op, reg_dest
  - mem_ctrl_t bundle: mem_read, mem_write, branch
  - wb_ctrl_t bundle: reg_write, mem_to_reg
  - the constant REG_ZERO = 3'd0
- One sub-module, hazard_detect, holds the purely combinational hazard equation. The registers, priority logic and counters live in id_ex_stage.

## Test plan
- Straight line: load add with rd1_id=16'h0005, imm_id=16'hFFFE, rs=1, rt=2, rd=3, reg_write_id=1 -> next edge gives data1ALU=0005, address=FFFE, reg3=3, valid_ex=1, stall=0.
- Load-use: load to rt=2 (mem_read_id=1), then add with use_rs_id=1 and rs_id=2 -> stall=1 for exactly one cycle. Then a bubble: valid_ex=0 with all control bits 0, bubble_cnt=1. The add reaches EX one cycle later.
- Load to register 0 followed by a reader of register 0 -> stall stays 0 and no bubble is injected.
- Same cycle as a load-use hazard, assert flush=1 -> stall=0, slot cleared, flush_cnt=1, bubble_cnt=0.
- Assert hold for 3 cycles during a hazard -> outputs frozen, stall=0, counters unchanged. After hold drops, one bubble is injected.
- Preload bubble_cnt to 16'hFFFF via repeated hazards (or with CNT_W=2, force 4 hazards) -> counter stays at maximum. Assert reset_n low between edges -> all outputs go to 0 immediately.
